// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin arbiter driving the 3x8 decoder sel/en of a shared tri-state line
// with turnaround gaps; define ARB_TIMEOUT_EN to add a forced release after HOLD_MAX cycles
module rr_bus_arbiter #(
   parameter int TURNAROUND = 1,
   parameter int HOLD_MAX = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] sel,
   output logic       en,
   output logic       busy,
   output logic       timeout
);
   localparam int TW = $clog2(TURNAROUND + 1);
   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
   state_t state;
   logic [2:0] ptr, pick, c;
   logic [TW-1:0] gap_cnt;
   logic force_rel;
   if (TURNAROUND < 1 || HOLD_MAX < 2) begin : g_bad_params
      $error("rr_bus_arbiter: TURNAROUND must be >= 1 and HOLD_MAX >= 2");
   end
   // descending scan so the closest source after ptr is written last and wins
   always_comb begin
      pick = ptr;
      c = ptr;
      for (int k = 8; k >= 1; k--) begin
         c = ptr + 3'(k);
         if (req[c]) pick = c;
      end
   end
`ifdef ARB_TIMEOUT_EN
   localparam int HW = $clog2(HOLD_MAX);
   logic [HW-1:0] hold;
   always_ff @(posedge clk) begin
      if (rst || state != GRANT) hold <= '0;
      else if (hold != HW'(HOLD_MAX - 1)) hold <= hold + HW'(1);
   end
   assign force_rel = (hold == HW'(HOLD_MAX - 1)) && |(req & ~gnt);
`else
   assign force_rel = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt <= '0;
         sel <= '0;
         en <= 1'b0;
         busy <= 1'b0;
         timeout <= 1'b0;
         ptr <= 3'd7;
         gap_cnt <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: if (|req) begin
               state <= GRANT;
               gnt <= 8'(1) << pick;
               sel <= pick;
               en <= 1'b1;
               busy <= 1'b1;
            end
            GRANT: if (!req[sel] || force_rel) begin
               state <= GAP;
               gnt <= '0;
               en <= 1'b0;
               ptr <= sel;
               gap_cnt <= '0;
               timeout <= req[sel];
            end
            GAP: if (gap_cnt == TW'(TURNAROUND - 1)) begin
               state <= IDLE;
               busy <= 1'b0;
            end else gap_cnt <= gap_cnt + TW'(1);
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter: directed checks of rr_bus_arbiter with TURNAROUND=1, HOLD_MAX=16
module tb_rr_bus_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   logic [7:0] req = '0;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic en, busy, timeout;
   int checks = 0, errors = 0;
   logic [7:0] bit_k;

   rr_bus_arbiter #(.TURNAROUND(1), .HOLD_MAX(16)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt), .sel(sel),
      .en(en), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] g, input logic [2:0] s,
                      input logic e, input logic b, input logic t);
      logic [13:0] obs, exp;
      obs = {gnt, sel, en, busy, timeout};
      exp = {g, s, e, b, t};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got gnt=%h sel=%0d en=%b busy=%b timeout=%b, expected gnt=%h sel=%0d en=%b busy=%b timeout=%b",
                tag, gnt, sel, en, busy, timeout, g, s, e, b, t);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      // 1: reset and idle
      do_reset();
      chk("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      step();
      chk("idle_a", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      step();
      chk("idle_b", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      // 2: single grant, release, gap
      req = 8'h01;
      step();
      chk("t2_grant", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
      req = 8'h00;
      step();
      chk("t2_gap", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
      step();
      chk("t2_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      step();
      chk("t2_idle2", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      // 3: two requesters alternate 0,7,0,7
      do_reset();
      req = 8'h81;
      for (int r = 0; r < 4; r++) begin
         automatic logic [2:0] s = (r % 2 == 0) ? 3'd0 : 3'd7;
         bit_k = 8'(1) << s;
         step();
         chk($sformatf("t3_g%0d_c1", r), bit_k, s, 1'b1, 1'b1, 1'b0);
         step();
         chk($sformatf("t3_g%0d_c2", r), bit_k, s, 1'b1, 1'b1, 1'b0);
         step();
         chk($sformatf("t3_g%0d_c3", r), bit_k, s, 1'b1, 1'b1, 1'b0);
         req = 8'h81 & ~bit_k;
         step();
         chk($sformatf("t3_g%0d_gap", r), 8'h00, s, 1'b0, 1'b1, 1'b0);
         req = 8'h81;
         step();
         chk($sformatf("t3_g%0d_idle", r), 8'h00, s, 1'b0, 1'b0, 1'b0);
      end
      // 4: all requesting, order 0..7 then wrap to 0
      do_reset();
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         automatic logic [2:0] s = 3'(k % 8);
         bit_k = 8'(1) << s;
         step();
         chk($sformatf("t4_src%0d_c1", k), bit_k, s, 1'b1, 1'b1, 1'b0);
         step();
         chk($sformatf("t4_src%0d_c2", k), bit_k, s, 1'b1, 1'b1, 1'b0);
         req = 8'hFF & ~bit_k;
         step();
         chk($sformatf("t4_src%0d_gap", k), 8'h00, s, 1'b0, 1'b1, 1'b0);
         req = 8'hFF;
         step();
         chk($sformatf("t4_src%0d_idle", k), 8'h00, s, 1'b0, 1'b0, 1'b0);
      end
      // 5: reset mid-grant, then regrant
      do_reset();
      req = 8'h10;
      step();
      chk("t5_grant", 8'h10, 3'd4, 1'b1, 1'b1, 1'b0);
      step();
      chk("t5_hold", 8'h10, 3'd4, 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      step();
      chk("t5_reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      chk("t5_regrant", 8'h10, 3'd4, 1'b1, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
      // 6: forced release with a competitor, persistence without one
      do_reset();
      req = 8'h04;
      step();
      chk("t6_c1", 8'h04, 3'd2, 1'b1, 1'b1, 1'b0);
      for (int c = 2; c <= 16; c++) begin
         step();
         chk($sformatf("t6_c%0d", c), 8'h04, 3'd2, 1'b1, 1'b1, 1'b0);
         if (c == 3) req = 8'h24;
      end
      step();
      chk("t6_forced", 8'h00, 3'd2, 1'b0, 1'b1, 1'b1);
      step();
      chk("t6_idle", 8'h00, 3'd2, 1'b0, 1'b0, 1'b0);
      step();
      chk("t6_next", 8'h20, 3'd5, 1'b1, 1'b1, 1'b0);
      do_reset();
      req = 8'h04;
      for (int c = 1; c <= 20; c++) begin
         step();
         chk($sformatf("t6_keep%0d", c), 8'h04, 3'd2, 1'b1, 1'b1, 1'b0);
      end
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
